// File: rtl/io_mmio_pkg.sv
// Register map and bit positions for the buffered memory-mapped IO block.
package io_mmio_pkg;

    // Register offsets relative to the IO window base.
    localparam logic [31:0] OFF_STATUS     = 32'h00;
    localparam logic [31:0] OFF_RXDATA     = 32'h04;
    localparam logic [31:0] OFF_TXDATA     = 32'h08;
    localparam logic [31:0] OFF_CTRL       = 32'h0C;
    localparam logic [31:0] OFF_CYCLE      = 32'h10;
    localparam logic [31:0] OFF_CNT_CLR    = 32'h18;
    localparam logic [31:0] OFF_EVENT_BASE = 32'h20;

    // STATUS bit positions.
    localparam int ST_TX_NOT_FULL  = 0;
    localparam int ST_RX_NOT_EMPTY = 1;
    localparam int ST_TX_OVERFLOW  = 2;
    localparam int ST_RX_UNDERFLOW = 3;
    localparam int ST_RX_COUNT_LSB = 8;
    localparam int ST_TX_COUNT_LSB = 16;

    // CTRL bit positions.
    localparam int CTRL_CLR_FLAGS = 0;
    localparam int CTRL_FLUSH     = 1;

    // Absolute address of a register inside a window.
    function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [31:0] off);
        return base + off;
    endfunction

endpackage

// File: rtl/io_mmio_buffered_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush; head reads zero while empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    input  logic                    flush,
    output logic [WIDTH-1:0]        head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok, mem_we;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign mem_we  = push_ok && !flush && !rst;
    assign count   = count_q;
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    // Next pointers and count; a flush discards any push or pop in the same cycle.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
            else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; count marks which entries are valid and head is masked while empty.
        if (mem_we) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/io_mmio_buffered.sv
// CPU-side IO window: buffered UART RX/TX, sticky error flags, cycle and event counters.
module io_mmio_buffered
    import io_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          NUM_CNT    = 4,
    parameter int          CNT_WIDTH  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_en,
    input  logic [31:0]        ld_addr,
    output logic [31:0]        ld_data,
    input  logic               st_en,
    input  logic [31:0]        st_addr,
    input  logic [31:0]        st_data,
    input  logic [NUM_CNT-1:0] cnt_event,
    input  logic [7:0]         uart_rx_data,
    input  logic               uart_rx_valid,
    output logic               uart_rx_ready,
    output logic [7:0]         uart_tx_data,
    output logic               uart_tx_valid,
    input  logic               uart_tx_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    rx_head, tx_head;
    logic [CW-1:0] rx_count, tx_count;
    logic          rx_full, rx_empty, tx_full, tx_empty;

    logic ld_rxdata, st_txdata, st_ctrl, st_cnt_clr;
    logic rx_pop, rx_udf_set, tx_push, tx_ovf_set, tx_pop;
    logic flush, clr_flags;

    logic tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;
    logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0] ev_val [NUM_CNT];
    logic [31:0]          status;
    logic                 unused_st_data;

    // Exact-address decode of the access strobes.
    assign ld_rxdata  = ld_en && (ld_addr == reg_addr(BASE_ADDR, OFF_RXDATA));
    assign st_txdata  = st_en && (st_addr == reg_addr(BASE_ADDR, OFF_TXDATA));
    assign st_ctrl    = st_en && (st_addr == reg_addr(BASE_ADDR, OFF_CTRL));
    assign st_cnt_clr = st_en && (st_addr == reg_addr(BASE_ADDR, OFF_CNT_CLR));

    assign rx_pop     = ld_rxdata && !rx_empty;
    assign rx_udf_set = ld_rxdata && rx_empty;
    assign tx_push    = st_txdata && !tx_full;
    assign tx_ovf_set = st_txdata && tx_full;
    assign tx_pop     = uart_tx_valid && uart_tx_ready;
    assign flush      = st_ctrl && st_data[CTRL_FLUSH];
    assign clr_flags  = st_ctrl && st_data[CTRL_CLR_FLAGS];

    // Handshakes are held off while reset is asserted.
    assign uart_rx_ready = !rst && !rx_full;
    assign uart_tx_valid = !rst && !tx_empty;
    assign uart_tx_data  = tx_head;

    // Only the low byte of a store carries TX data; CTRL uses two bits of it.
    assign unused_st_data = ^st_data[31:8];

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (uart_rx_valid && uart_rx_ready),
        .push_data (uart_rx_data),
        .pop       (rx_pop),
        .flush     (flush),
        .head      (rx_head),
        .count     (rx_count),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (st_data[7:0]),
        .pop       (tx_pop),
        .flush     (flush),
        .head      (tx_head),
        .count     (tx_count),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    // Sticky flags: a set in the same cycle as a clear wins.
    always_comb begin
        tx_ovf_d = tx_ovf_q;
        rx_udf_d = rx_udf_q;
        if (clr_flags) begin
            tx_ovf_d = 1'b0;
            rx_udf_d = 1'b0;
        end
        if (tx_ovf_set) tx_ovf_d = 1'b1;
        if (rx_udf_set) rx_udf_d = 1'b1;
    end

    // Sticky flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_ovf_q <= 1'b0;
            rx_udf_q <= 1'b0;
        end else begin
            tx_ovf_q <= tx_ovf_d;
            rx_udf_q <= rx_udf_d;
        end
    end

    // Free-running cycle counter; a counter clear beats the increment.
    always_comb begin
        cycle_d = st_cnt_clr ? '0 : cycle_q + CNT_WIDTH'(1);
    end

    // Cycle counter register.
    always_ff @(posedge clk) begin
        if (rst) cycle_q <= '0;
        else     cycle_q <= cycle_d;
    end

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_evt
        logic [CNT_WIDTH-1:0] ev_q, ev_d;

        // Event counter: increments on its strobe, cleared by a CNT_CLR store.
        always_comb begin
            ev_d = ev_q;
            if (st_cnt_clr)        ev_d = '0;
            else if (cnt_event[i]) ev_d = ev_q + CNT_WIDTH'(1);
        end

        // Event counter register.
        always_ff @(posedge clk) begin
            if (rst) ev_q <= '0;
            else     ev_q <= ev_d;
        end

        assign ev_val[i] = ev_q;
    end

    // STATUS word assembly.
    always_comb begin
        status                          = '0;
        status[ST_TX_NOT_FULL]          = !tx_full;
        status[ST_RX_NOT_EMPTY]         = !rx_empty;
        status[ST_TX_OVERFLOW]          = tx_ovf_q;
        status[ST_RX_UNDERFLOW]         = rx_udf_q;
        status[ST_RX_COUNT_LSB +: 8]    = 8'(rx_count);
        status[ST_TX_COUNT_LSB +: 8]    = 8'(tx_count);
    end

    // Combinational read mux; unmapped and write-only addresses read zero.
    always_comb begin
        ld_data = '0;
        if (ld_addr == reg_addr(BASE_ADDR, OFF_STATUS))      ld_data = status;
        else if (ld_addr == reg_addr(BASE_ADDR, OFF_RXDATA)) ld_data = {24'd0, rx_head};
        else if (ld_addr == reg_addr(BASE_ADDR, OFF_CYCLE))  ld_data = 32'(cycle_q);
        for (int i = 0; i < NUM_CNT; i++) begin
            if (ld_addr == reg_addr(BASE_ADDR, OFF_EVENT_BASE + 32'(4 * i))) ld_data = 32'(ev_val[i]);
        end
    end

endmodule

// File: tb/tb_io_mmio_buffered.sv
// Bench for io_mmio_buffered: directed scenarios then random traffic against a queue-based model.
module tb_io_mmio_buffered;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 8;
    localparam int          NCNT  = 4;
    localparam int          CWID  = 8;
    localparam int unsigned MASK  = (CWID == 32) ? 32'hFFFF_FFFF : ((32'd1 << CWID) - 32'd1);

    localparam logic [31:0] A_STATUS = BASE + 32'h00;
    localparam logic [31:0] A_RXDATA = BASE + 32'h04;
    localparam logic [31:0] A_TXDATA = BASE + 32'h08;
    localparam logic [31:0] A_CTRL   = BASE + 32'h0C;
    localparam logic [31:0] A_CYCLE  = BASE + 32'h10;
    localparam logic [31:0] A_CNTCLR = BASE + 32'h18;
    localparam logic [31:0] A_EVENT  = BASE + 32'h20;

    logic            clk = 1'b0;
    logic            rst;
    logic            ld_en;
    logic [31:0]     ld_addr;
    logic [31:0]     ld_data;
    logic            st_en;
    logic [31:0]     st_addr;
    logic [31:0]     st_data;
    logic [NCNT-1:0] cnt_event;
    logic [7:0]      uart_rx_data;
    logic            uart_rx_valid;
    logic            uart_rx_ready;
    logic [7:0]      uart_tx_data;
    logic            uart_tx_valid;
    logic            uart_tx_ready;

    always #5 clk = ~clk;

    io_mmio_buffered #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH),
        .NUM_CNT    (NCNT),
        .CNT_WIDTH  (CWID)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ld_en         (ld_en),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .st_en         (st_en),
        .st_addr       (st_addr),
        .st_data       (st_data),
        .cnt_event     (cnt_event),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready)
    );

    // Reference model state.
    byte unsigned rxq[$];
    byte unsigned txq[$];
    bit           m_ovf, m_udf;
    int unsigned  m_cyc;
    int unsigned  m_ev [NCNT];

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        bit txnf, rxne;
        txnf = (txq.size() < DEPTH);
        rxne = (rxq.size() != 0);
        if (a == A_STATUS)
            return {8'd0, 8'(txq.size()), 8'(rxq.size()), 4'd0, m_udf, m_ovf, rxne, txnf};
        if (a == A_RXDATA) return (rxq.size() != 0) ? {24'd0, rxq[0]} : 32'd0;
        if (a == A_CYCLE)  return m_cyc;
        for (int i = 0; i < NCNT; i++)
            if (a == A_EVENT + 32'(4 * i)) return m_ev[i];
        return 32'd0;
    endfunction

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_step();
        bit rx_pop, rx_push, tx_pop, tx_push, ovf_set, udf_set, flush, clr, cclr;
        if (rst) begin
            rxq.delete();
            txq.delete();
            m_ovf = 0;
            m_udf = 0;
            m_cyc = 0;
            for (int i = 0; i < NCNT; i++) m_ev[i] = 0;
            return;
        end
        rx_pop  = ld_en && (ld_addr == A_RXDATA) && (rxq.size() > 0);
        udf_set = ld_en && (ld_addr == A_RXDATA) && (rxq.size() == 0);
        rx_push = uart_rx_valid && (rxq.size() < DEPTH);
        tx_push = st_en && (st_addr == A_TXDATA) && (txq.size() < DEPTH);
        ovf_set = st_en && (st_addr == A_TXDATA) && (txq.size() >= DEPTH);
        tx_pop  = (txq.size() > 0) && uart_tx_ready;
        flush   = st_en && (st_addr == A_CTRL) && st_data[1];
        clr     = st_en && (st_addr == A_CTRL) && st_data[0];
        cclr    = st_en && (st_addr == A_CNTCLR);
        if (flush) begin
            rxq.delete();
            txq.delete();
        end else begin
            if (rx_pop)  void'(rxq.pop_front());
            if (rx_push) rxq.push_back(uart_rx_data);
            if (tx_pop)  void'(txq.pop_front());
            if (tx_push) txq.push_back(st_data[7:0]);
        end
        if (clr) begin
            m_ovf = 0;
            m_udf = 0;
        end
        if (ovf_set) m_ovf = 1;
        if (udf_set) m_udf = 1;
        if (cclr) begin
            m_cyc = 0;
            for (int i = 0; i < NCNT; i++) m_ev[i] = 0;
        end else begin
            m_cyc = (m_cyc + 1) & MASK;
            for (int i = 0; i < NCNT; i++) m_ev[i] = (m_ev[i] + 32'(cnt_event[i])) & MASK;
        end
    endtask

    task automatic check_outputs();
        check("ld_data", ld_data, model_read(ld_addr));
        check("rx_ready", 32'(uart_rx_ready), 32'(!rst && (rxq.size() < DEPTH)));
        check("tx_valid", 32'(uart_tx_valid), 32'(!rst && (txq.size() > 0)));
        check("tx_data", 32'(uart_tx_data), (txq.size() > 0) ? 32'(txq[0]) : 32'd0);
    endtask

    // Check outputs mid-cycle, then advance one edge in both DUT and model.
    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        ld_en         = 1'b0;
        ld_addr       = A_STATUS;
        st_en         = 1'b0;
        st_addr       = 32'd0;
        st_data       = 32'd0;
        cnt_event     = '0;
        uart_rx_valid = 1'b0;
        uart_rx_data  = 8'd0;
        uart_tx_ready = 1'b0;
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] tbl [15];
        tbl = '{A_STATUS, A_RXDATA, A_TXDATA, A_CTRL, A_CYCLE, BASE + 32'h14, A_CNTCLR,
                BASE + 32'h1C, A_EVENT, A_EVENT + 32'h4, A_EVENT + 32'h8, A_EVENT + 32'hC,
                A_EVENT + 32'h10, BASE + 32'h5, 32'h0000_0004};
        return tbl[$urandom_range(0, 14)];
    endfunction

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        model_step();
        @(posedge clk);
        model_step();
        #1;
        check("rst_rx_ready", 32'(uart_rx_ready), 32'd0);
        check("rst_tx_valid", 32'(uart_tx_valid), 32'd0);
        tick();

        // Post-reset state.
        rst = 1'b0;
        #1;
        check("reset_status", ld_data, 32'h0000_0001);
        check("reset_rx_ready", 32'(uart_rx_ready), 32'd1);
        check("reset_tx_valid", 32'(uart_tx_valid), 32'd0);
        check("reset_tx_data", 32'(uart_tx_data), 32'd0);
        tick();

        // Two UART bytes in, read back in order, then an underflow read.
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'hA5;
        tick();
        uart_rx_data  = 8'h3C;
        tick();
        uart_rx_valid = 1'b0;
        ld_addr = A_STATUS;
        #1;
        check("rx_count_2", 32'(ld_data[15:8]), 32'd2);
        tick();
        ld_en   = 1'b1;
        ld_addr = A_RXDATA;
        #1;
        check("rx_read_a5", ld_data, 32'hA5);
        tick();
        #1;
        check("rx_read_3c", ld_data, 32'h3C);
        tick();
        #1;
        check("rx_read_empty", ld_data, 32'd0);
        tick();
        ld_en   = 1'b0;
        ld_addr = A_STATUS;
        #1;
        check("rx_underflow_flag", 32'(ld_data[3]), 32'd1);
        tick();

        // TX overflow: nine stores with the transmitter stalled.
        uart_tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            st_en   = 1'b1;
            st_addr = A_TXDATA;
            st_data = ($urandom() & 32'hFFFF_FF00) | 32'(i);
            tick();
        end
        st_en = 1'b0;
        #1;
        check("tx_count_8", 32'(ld_data[23:16]), 32'd8);
        check("tx_not_full_0", 32'(ld_data[0]), 32'd0);
        check("tx_overflow_flag", 32'(ld_data[2]), 32'd1);
        tick();
        uart_tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            #1;
            check("tx_drain_valid", 32'(uart_tx_valid), 32'd1);
            check("tx_drain_byte", 32'(uart_tx_data), 32'(i));
            tick();
        end
        #1;
        check("tx_drained", 32'(uart_tx_valid), 32'd0);
        tick();
        uart_tx_ready = 1'b0;

        // RX full: ready drops, then pop-only and pop-with-push cycles.
        uart_rx_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            uart_rx_data = 8'($urandom());
            tick();
        end
        uart_rx_data = 8'($urandom());
        #1;
        check("rx_full_ready", 32'(uart_rx_ready), 32'd0);
        check("rx_full_count", 32'(ld_data[15:8]), 32'd8);
        tick();
        ld_en   = 1'b1;
        ld_addr = A_RXDATA;
        tick();
        uart_rx_data = 8'($urandom());
        tick();
        ld_en         = 1'b0;
        uart_rx_valid = 1'b0;
        ld_addr       = A_STATUS;
        #1;
        check("rx_pop_push_count", 32'(ld_data[15:8]), 32'd7);
        tick();
        ld_en   = 1'b1;
        ld_addr = A_RXDATA;
        for (int i = 0; i < DEPTH; i++) tick();
        ld_en = 1'b0;

        // Event counter and clear priority.
        st_en   = 1'b1;
        st_addr = A_CNTCLR;
        tick();
        st_en     = 1'b0;
        cnt_event = 4'b0100;
        repeat (5) tick();
        ld_addr = A_EVENT + 32'h8;
        st_en   = 1'b1;
        st_addr = A_CNTCLR;
        #1;
        check("event2_before_clr", ld_data, 32'd5);
        tick();
        st_en     = 1'b0;
        cnt_event = '0;
        #1;
        check("event2_after_clr", ld_data, 32'd0);
        ld_addr = A_CYCLE;
        #1;
        check("cycle_restart", ld_data, 32'd0);
        tick();
        #1;
        check("cycle_one", ld_data, 32'd1);
        tick();

        // Flush with both FIFOs occupied, then clear the flags.
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            uart_rx_valid = 1'b1;
            uart_rx_data  = 8'($urandom());
            st_en         = 1'b1;
            st_addr       = A_TXDATA;
            st_data       = $urandom();
            tick();
        end
        uart_rx_valid = 1'b0;
        st_addr       = A_CTRL;
        st_data       = 32'h2;
        tick();
        st_en   = 1'b0;
        ld_addr = A_STATUS;
        #1;
        check("flush_counts", 32'(ld_data[23:8]), 32'd0);
        check("flush_tx_valid", 32'(uart_tx_valid), 32'd0);
        check("flags_kept", 32'(ld_data[3:2]), 32'd3);
        tick();
        st_en   = 1'b1;
        st_addr = A_CTRL;
        st_data = 32'h1;
        tick();
        st_en = 1'b0;
        #1;
        check("flags_cleared", 32'(ld_data[3:2]), 32'd0);
        tick();

        // Random traffic with phases biased toward filling or draining.
        for (int c = 0; c < 4000; c++) begin
            bit fill;
            fill          = ((c / 250) % 2) == 0;
            rst           = ($urandom_range(0, 299) == 0);
            uart_rx_valid = ($urandom_range(0, 3) < (fill ? 3 : 1));
            uart_rx_data  = 8'($urandom());
            uart_tx_ready = ($urandom_range(0, 3) < (fill ? 1 : 3));
            ld_en         = ($urandom_range(0, 3) < (fill ? 1 : 3));
            ld_addr       = pick_addr();
            st_en         = ($urandom_range(0, 2) == 0);
            st_addr       = pick_addr();
            st_data       = $urandom();
            if (st_addr == A_CNTCLR && $urandom_range(0, 15) != 0) st_addr = A_TXDATA;
            if (st_addr == A_CTRL && $urandom_range(0, 3) != 0)    st_data[1] = 1'b0;
            cnt_event     = NCNT'($urandom());
            tick();
        end

        idle();
        rst = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
